// File: rtl/fifo_arb_pkg.sv
// Shared constants for the FIFO write-port arbiter: FSM state encoding and
// the width of the per-lock beat counter.
package fifo_arb_pkg;

    // Arbiter FSM states (legacy-compatible constant encoding)
    localparam logic [0:0] ARB_IDLE   = 1'b0;
    localparam logic [0:0] ARB_LOCKED = 1'b1;

    // Width of the beat counter used while a burst lock is held
    localparam int BEAT_CNT_W = 8;

endpackage : fifo_arb_pkg

// File: rtl/fifo_arb_rr_pick.sv
// Rotating priority encoder: returns the first asserted request found when
// searching upward from ptr_i, wrapping from num_req-1 back to 0.
module fifo_arb_rr_pick #(
    parameter int num_req = 4,
    parameter int GW      = 2
) (
    input  logic [num_req-1:0] req_i,
    input  logic [GW-1:0]      ptr_i,
    output logic               found_o,
    output logic [GW-1:0]      idx_o
);

    int k;

    // Scan all requesters starting at the pointer; the first hit wins
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        k       = 0;
        for (int i = 0; i < num_req; i++) begin
            k = (int'(ptr_i) + i) % num_req;
            if (!found_o && req_i[k]) begin
                found_o = 1'b1;
                idx_o   = GW'(k);
            end
        end
    end

endmodule : fifo_arb_rr_pick

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between num_req requesters.
// Optional burst locking is compiled in when FIFO_ARB_BURST_EN is defined:
// the first winner then keeps the port for up to max_burst beats.
//
// Handshake: a beat transfers in any cycle where req_valid[i] && req_ready[i];
// req_ready is combinational from req_valid, fifo_full and registered state,
// is at most one-hot, and is all zero while fifo_full or reset is high.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int num_req    = 4,
    parameter  int data_width = 16,
    parameter  int max_burst  = 4,
    localparam int GW         = (num_req > 2) ? $clog2(num_req) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [num_req-1:0]            req_valid,
    input  logic [num_req*data_width-1:0] req_data,
    output logic [num_req-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [data_width-1:0]         fifo_wr_data,
    output logic [GW-1:0]                 grant_id,
    output logic                          busy,
    output logic [0:0]                    dbg_state
);

    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic [GW-1:0] grant_q, grant_d;
    logic          pick_found;
    logic [GW-1:0] pick_idx;
    logic [GW-1:0] sel;
    logic          sel_ok;
    logic          beat;

    function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] i);
        if (int'(i) == num_req - 1) return '0;
        else                        return i + 1'b1;
    endfunction

    fifo_arb_rr_pick #(.num_req(num_req), .GW(GW)) u_pick (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

`ifdef FIFO_ARB_BURST_EN
    logic [0:0]            state_q, state_d;
    logic [GW-1:0]         owner_q, owner_d;
    logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    // Choose candidate: lock owner while locked, rotating winner otherwise
    always_comb begin
        sel    = pick_idx;
        sel_ok = pick_found;
        if (state_q == ARB_LOCKED) begin
            sel    = owner_q;
            sel_ok = req_valid[owner_q];
        end
    end

    // Lock bookkeeping: enter on an idle beat, release on last beat or owner drop
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        if (!fifo_full) begin
            if (state_q == ARB_IDLE) begin
                if (beat) begin
                    if (max_burst == 1) begin
                        rr_ptr_d = next_idx(sel);
                    end else begin
                        state_d    = ARB_LOCKED;
                        owner_d    = sel;
                        beat_cnt_d = BEAT_CNT_W'(1);
                    end
                end
            end else if (beat && (beat_cnt_q + 1'b1) != BEAT_CNT_W'(max_burst)) begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end else begin
                // Final beat of the burst, or the owner went away (bubble cycle)
                state_d    = ARB_IDLE;
                beat_cnt_d = '0;
                rr_ptr_d   = next_idx(owner_q);
            end
        end
    end

    // Lock state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            owner_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign busy      = (state_q == ARB_LOCKED) && !reset;
    assign dbg_state = state_q;
`else
    // Without locking the rotating winner is always the candidate
    always_comb begin
        sel    = pick_idx;
        sel_ok = pick_found;
    end

    // Rotate past the winner after every accepted beat
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (beat) rr_ptr_d = next_idx(sel);
    end

    assign busy      = 1'b0;
    assign dbg_state = ARB_IDLE;
`endif

    // Grant decode and write-port steering; everything is forced low in reset
    always_comb begin
        req_ready = '0;
        if (!reset && !fifo_full && sel_ok) req_ready[sel] = 1'b1;
        beat         = |req_ready;
        fifo_wr_en   = beat;
        fifo_wr_data = beat ? req_data[int'(sel)*data_width +: data_width] : '0;
        grant_d      = beat ? sel : grant_q;
        grant_id     = reset ? '0 : grant_d;
    end

    // Pointer and last-grant registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
            grant_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
        end
    end

endmodule : fifo_wr_arbiter
